// File: rtl/sram_array_ctrl_if.sv
// Request/response stream between a requester and the SRAM access sequencer.
interface sram_array_ctrl_if #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 8
);
  localparam int unsigned MASK_W = DATA_W / 8;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [MASK_W-1:0] req_wmask;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;

  // Requester side
  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_wmask, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata
  );

  // Controller side
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_wmask, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/sram_array_ctrl.sv
// Access sequencer for a compiled SRAM macro: timed write/sense strobes,
// recovery gaps, byte-masked writes via read-modify-write, held response.
module sram_array_ctrl #(
  parameter int unsigned ADDR_W         = 12,
  parameter int unsigned DATA_W         = 8,
  parameter int unsigned WR_CYCLES      = 2,
  parameter int unsigned SENSE_CYCLES   = 1,
  parameter int unsigned RECOVER_CYCLES = 1
) (
  input  logic              clk,
  input  logic              resetn,
  sram_array_ctrl_if.slave  bus,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_din,
  output logic              sram_write_en,
  output logic              sram_sense_en,
  input  logic [DATA_W-1:0] sram_dout
);

  localparam int unsigned MASK_W = DATA_W / 8;
  localparam int unsigned MAX_WS = (WR_CYCLES > SENSE_CYCLES) ? WR_CYCLES : SENSE_CYCLES;
  localparam int unsigned MAX_C  = (MAX_WS > RECOVER_CYCLES) ? MAX_WS : RECOVER_CYCLES;
  localparam int unsigned CNT_W  = $clog2(MAX_C + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SENSE   = 3'd1,
    MERGE   = 3'd2,
    WRITE   = 3'd3,
    RECOVER = 3'd4,
    RESP    = 3'd5
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ready_q, ready_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic              we_q, we_d;
  logic              sense_n_q, sense_n_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [MASK_W-1:0] wmask_q, wmask_d;
  logic              is_wr_q, is_wr_d;
  logic [DATA_W-1:0] cap_q, cap_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

  logic [DATA_W-1:0] merged;
  logic              sense_last, wr_last, rec_last;

  assign sense_last = (cnt_q == CNT_W'(SENSE_CYCLES - 1));
  assign wr_last    = (cnt_q == CNT_W'(WR_CYCLES - 1));
  assign rec_last   = (cnt_q == CNT_W'(RECOVER_CYCLES - 1));

  // Byte-wise merge of new write data over the sensed word
  always_comb begin
    merged = cap_q;
    for (int i = 0; i < int'(MASK_W); i++) begin
      if (wmask_q[i]) merged[8*i +: 8] = wdata_q[8*i +: 8];
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ready_d     = ready_q;
    addr_d      = addr_q;
    din_d       = din_q;
    we_d        = we_q;
    sense_n_d   = sense_n_q;
    wdata_d     = wdata_q;
    wmask_d     = wmask_q;
    is_wr_d     = is_wr_q;
    cap_d       = cap_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;

    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          ready_d = 1'b0;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          wmask_d = bus.req_wmask;
          is_wr_d = bus.req_we;
          cnt_d   = '0;
          if (!bus.req_we) begin
            sense_n_d = 1'b0;
            state_d   = SENSE;
          end else if (bus.req_wmask == '0) begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = '0;
            state_d     = RESP;
          end else if (bus.req_wmask == {MASK_W{1'b1}}) begin
            din_d   = bus.req_wdata;
            we_d    = 1'b1;
            state_d = WRITE;
          end else begin
            sense_n_d = 1'b0;
            state_d   = SENSE;
          end
        end
      end
      SENSE: begin
        if (sense_last) begin
          sense_n_d = 1'b1;
          cap_d     = sram_dout;
          cnt_d     = '0;
          if (is_wr_q) begin
            state_d = MERGE;
          end else begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = sram_dout;
            state_d     = RESP;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      MERGE: begin
        din_d   = merged;
        we_d    = 1'b1;
        cnt_d   = '0;
        state_d = WRITE;
      end
      WRITE: begin
        if (wr_last) begin
          we_d    = 1'b0;
          cnt_d   = '0;
          state_d = RECOVER;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RECOVER: begin
        if (rec_last) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          ready_d     = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        ready_d     = 1'b1;
        we_d        = 1'b0;
        sense_n_d   = 1'b1;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset drops both strobes immediately
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ready_q     <= 1'b1;
      addr_q      <= '0;
      din_q       <= '0;
      we_q        <= 1'b0;
      sense_n_q   <= 1'b1;
      wdata_q     <= '0;
      wmask_q     <= '0;
      is_wr_q     <= 1'b0;
      cap_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ready_q     <= ready_d;
      addr_q      <= addr_d;
      din_q       <= din_d;
      we_q        <= we_d;
      sense_n_q   <= sense_n_d;
      wdata_q     <= wdata_d;
      wmask_q     <= wmask_d;
      is_wr_q     <= is_wr_d;
      cap_q       <= cap_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign sram_addr     = addr_q;
  assign sram_din      = din_q;
  assign sram_write_en = we_q;
  assign sram_sense_en = sense_n_q;

endmodule

// File: tb/tb_sram_array_ctrl.sv
// Directed and seeded-random bench for sram_array_ctrl (32-bit word, default timing).
module tb_sram_array_ctrl;

  localparam int unsigned ADDR_W = 12;
  localparam int unsigned DATA_W = 32;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_din;
  logic              sram_write_en;
  logic              sram_sense_en;
  logic [DATA_W-1:0] sram_dout;

  logic [DATA_W-1:0] mem     [4096] = '{default: '0};
  logic [DATA_W-1:0] ref_mem [4096] = '{default: '0};

  int n_chk = 0;
  int n_pass = 0;
  int we_cnt = 0;
  int se_cnt = 0;
  int overlap = 0;

  sram_array_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  sram_array_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .WR_CYCLES(2), .SENSE_CYCLES(1), .RECOVER_CYCLES(1)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .bus           (bus),
    .sram_addr     (sram_addr),
    .sram_din      (sram_din),
    .sram_write_en (sram_write_en),
    .sram_sense_en (sram_sense_en),
    .sram_dout     (sram_dout)
  );

  always #5 clk = ~clk;

  // Behavioural SRAM macro
  always @(posedge clk) if (sram_write_en) mem[sram_addr] <= sram_din;
  assign sram_dout = sram_sense_en ? '0 : mem[sram_addr];

  // Strobe activity and overlap monitor
  always @(negedge clk) begin
    if (sram_write_en) we_cnt <= we_cnt + 1;
    if (!sram_sense_en) se_cnt <= se_cnt + 1;
    if (sram_write_en && !sram_sense_en) overlap <= overlap + 1;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
  endtask

  task automatic do_op(input logic we, input logic [ADDR_W-1:0] addr,
                       input logic [DATA_W-1:0] wd, input logic [3:0] wm,
                       input int hold, input logic [DATA_W-1:0] exp_rd,
                       output logic [DATA_W-1:0] rd, output int lat,
                       output int wec, output int sec);
    int k;
    int we0;
    int se0;
    rd = '0; lat = 0; wec = 0; sec = 0;
    @(negedge clk);
    k = 0;
    while (!bus.req_ready && k < 50) begin @(negedge clk); k++; end
    if (!bus.req_ready) begin check("ready_timeout", 32'd0, 32'd1); return; end
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_addr = addr;
    bus.req_wdata = wd; bus.req_wmask = wm;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    we0 = we_cnt; se0 = se_cnt;
    k = 0;
    while (!bus.rsp_valid && k < 50) begin @(posedge clk); #1; k++; end
    if (!bus.rsp_valid) begin check("rsp_timeout", 32'd0, 32'd1); return; end
    lat = k + 1;
    rd = bus.rsp_rdata;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_valid", 32'(bus.rsp_valid), 32'd1);
      check("hold_rdata", bus.rsp_rdata, exp_rd);
      check("hold_ready", 32'(bus.req_ready), 32'd0);
      check("hold_strobes", {30'd0, sram_write_en, sram_sense_en}, 32'd1);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    check("rsp_drop", 32'(bus.rsp_valid), 32'd0);
    check("ready_back", 32'(bus.req_ready), 32'd1);
    wec = we_cnt - we0;
    sec = se_cnt - se0;
  endtask

  initial begin
    logic [DATA_W-1:0] rd;
    logic [DATA_W-1:0] wd;
    logic [DATA_W-1:0] exp;
    logic [ADDR_W-1:0] a;
    logic [3:0]        m;
    logic              w;
    int lat, wec, sec, elat;

    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0;
    bus.req_wdata = '0; bus.req_wmask = '0; bus.rsp_ready = 1'b0;

    // Reset values
    #12;
    check("rst_ready", 32'(bus.req_ready), 32'd1);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rdata", bus.rsp_rdata, 32'd0);
    check("rst_addr", 32'(sram_addr), 32'd0);
    check("rst_din", sram_din, 32'd0);
    check("rst_strobes", {30'd0, sram_write_en, sram_sense_en}, 32'd1);
    @(negedge clk); resetn = 1'b1;

    // Reset during the first write cycle
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 12'h100;
    bus.req_wdata = 32'hDEADBEEF; bus.req_wmask = 4'hF;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    check("midwr_we_high", 32'(sram_write_en), 32'd1);
    #2; resetn = 1'b0; #1;
    check("midwr_we_drop", 32'(sram_write_en), 32'd0);
    check("midwr_sense", 32'(sram_sense_en), 32'd1);
    check("midwr_rsp", 32'(bus.rsp_valid), 32'd0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(posedge clk); #1;
    check("midwr_ready", 32'(bus.req_ready), 32'd1);
    @(posedge clk); #1;
    check("midwr_no_rsp", 32'(bus.rsp_valid), 32'd0);
    do_op(1'b1, 12'h100, 32'h0, 4'hF, 0, 32'h0, rd, lat, wec, sec);
    ref_mem[12'h100] = 32'h0;

    // Full write then read
    do_op(1'b1, 12'h0A5, 32'h0000003C, 4'hF, 0, 32'h0, rd, lat, wec, sec);
    ref_mem[12'h0A5] = 32'h0000003C;
    check("fw_lat", 32'(lat), 32'd4);
    check("fw_we_cycles", 32'(wec), 32'd2);
    check("fw_sense_cycles", 32'(sec), 32'd0);
    check("fw_rdata", rd, 32'd0);
    do_op(1'b0, 12'h0A5, 32'h0, 4'h0, 0, 32'h0, rd, lat, wec, sec);
    check("rd_data", rd, 32'h0000003C);
    check("rd_lat", 32'(lat), 32'd2);
    check("rd_sense_cycles", 32'(sec), 32'd1);
    check("rd_we_cycles", 32'(wec), 32'd0);

    // Partial-mask read-modify-write
    do_op(1'b1, 12'h7FF, 32'h11223344, 4'hF, 0, 32'h0, rd, lat, wec, sec);
    do_op(1'b1, 12'h7FF, 32'hAABBCCDD, 4'b0101, 0, 32'h0, rd, lat, wec, sec);
    ref_mem[12'h7FF] = 32'h11BB33DD;
    check("rmw_lat", 32'(lat), 32'd6);
    check("rmw_sense_cycles", 32'(sec), 32'd1);
    check("rmw_we_cycles", 32'(wec), 32'd2);
    do_op(1'b0, 12'h7FF, 32'h0, 4'h0, 0, 32'h0, rd, lat, wec, sec);
    check("rmw_readback", rd, 32'h11BB33DD);

    // Zero-mask write touches nothing
    do_op(1'b1, 12'h010, 32'h5A5A5A5A, 4'hF, 0, 32'h0, rd, lat, wec, sec);
    ref_mem[12'h010] = 32'h5A5A5A5A;
    do_op(1'b1, 12'h010, 32'hFFFFFFFF, 4'h0, 0, 32'h0, rd, lat, wec, sec);
    check("m0_lat", 32'(lat), 32'd1);
    check("m0_we_cycles", 32'(wec), 32'd0);
    check("m0_sense_cycles", 32'(sec), 32'd0);
    do_op(1'b0, 12'h010, 32'h0, 4'h0, 0, 32'h0, rd, lat, wec, sec);
    check("m0_readback", rd, 32'h5A5A5A5A);

    // Back-pressured response held for 5 cycles
    do_op(1'b0, 12'h7FF, 32'h0, 4'h0, 5, 32'h11BB33DD, rd, lat, wec, sec);
    check("bp_rdata", rd, 32'h11BB33DD);
    check("bp_sense_cycles", 32'(sec), 32'd1);

    // Random traffic against the reference model, corners first
    for (int i = 0; i < 100; i++) begin
      w  = 1'($urandom_range(0, 1));
      a  = 12'($urandom_range(0, 4095));
      wd = $urandom;
      m  = 4'($urandom_range(0, 15));
      if (i == 0) begin w = 1'b1; a = 12'h000; m = 4'hF; end
      if (i == 1) begin w = 1'b1; a = 12'hFFF; m = 4'b1010; end
      if (i == 2) begin w = 1'b0; a = 12'h000; end
      if (i == 3) begin w = 1'b0; a = 12'hFFF; end
      if (!w)            elat = 2;
      else if (m == 4'h0) elat = 1;
      else if (m == 4'hF) elat = 4;
      else               elat = 6;
      exp = w ? 32'h0 : ref_mem[a];
      do_op(w, a, wd, m, 0, 32'h0, rd, lat, wec, sec);
      check(w ? "rnd_wr_rdata" : "rnd_rd_data", rd, exp);
      check("rnd_lat", 32'(lat), 32'(elat));
      if (w) begin
        for (int b = 0; b < 4; b++) begin
          if (m[b]) ref_mem[a][8*b +: 8] = wd[8*b +: 8];
        end
      end
    end

    check("no_overlap", 32'(overlap), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
